// File: rtl/mbr_sync.sv
// Frame-marker receiver: counts slots between marker falling edges, acquires
// lock after consecutive well-spaced markers and flywheels through faults.
module mbr_sync #(
  parameter int FRAME_LEN   = 40,
  parameter int LOCK_FRAMES = 3,
  parameter int LOSS_FRAMES = 2,
  parameter int CW          = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i320,
  input  logic          iMBR,
  output logic [CW-1:0] oSlot,
  output logic          oFrame,
  output logic          oLock,
  output logic          oErr,
  output logic [7:0]    oErrCnt
);

  localparam int GW = $clog2(LOCK_FRAMES + 1);
  localparam int FW = $clog2(LOSS_FRAMES + 1);
  localparam logic [CW-1:0] FL     = CW'(FRAME_LEN);
  localparam logic [CW-1:0] FL_SAT = CW'(FRAME_LEN + 1);
  localparam logic [GW-1:0] LOCK_N = GW'(LOCK_FRAMES);
  localparam logic [FW-1:0] LOSS_N = FW'(LOSS_FRAMES);

  typedef enum logic [1:0] {S_HUNT, S_VERIFY, S_LOCK} state_e;

  // Edge-detect stage: previous raw samples and registered edge pulses.
  logic          i320_d_q, mbr_d_q;
  logic          slot_q, slot_d;
  logic          mark_q, mark_d;

  // Framing core.
  state_e        state_q, state_d;
  logic [CW-1:0] dcnt_q, dcnt_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic [7:0]    errcnt_q, errcnt_d;
  logic          frame_q, frame_d;
  logic          err_q, err_d;

  // Output register bank.
  logic [CW-1:0] slot_out_q;
  logic          frame_out_q, lock_out_q, err_out_q;
  logic [7:0]    errcnt_out_q;

  logic [CW-1:0] dcnt_inc, dcnt_rst;
  logic          good, early, missing, fault;

  always_comb begin
    slot_d = i320 & ~i320_d_q;
    mark_d = mbr_d_q & ~iMBR;
  end

  // Markers are judged on dcnt before this cycle's slot is counted.
  always_comb begin
    dcnt_inc = (slot_q && dcnt_q != FL_SAT) ? dcnt_q + CW'(1) : dcnt_q;
    dcnt_rst = {{(CW-1){1'b0}}, slot_q};
    good     = mark_q && (dcnt_q == FL);
    early    = mark_q && (dcnt_q < FL);
    missing  = slot_q && !mark_q && (dcnt_q == FL);
  end

  always_comb begin
    state_d  = state_q;
    dcnt_d   = dcnt_inc;
    gcnt_d   = gcnt_q;
    fcnt_d   = fcnt_q;
    errcnt_d = errcnt_q;
    frame_d  = 1'b0;
    err_d    = 1'b0;
    fault    = 1'b0;
    case (state_q)
      S_HUNT: begin
        if (mark_q) begin
          dcnt_d  = dcnt_rst;
          gcnt_d  = GW'(1);
          state_d = S_VERIFY;
        end
      end
      S_VERIFY: begin
        if (good) begin
          dcnt_d = dcnt_rst;
          gcnt_d = gcnt_q + GW'(1);
          if (gcnt_q == LOCK_N - GW'(1)) begin
            state_d = S_LOCK;
            frame_d = 1'b1;
            fcnt_d  = '0;
          end
        end else if (early) begin
          dcnt_d = dcnt_rst;
          gcnt_d = GW'(1);
        end else if (missing) begin
          state_d = S_HUNT;
        end
      end
      S_LOCK: begin
        if (good) begin
          dcnt_d  = dcnt_rst;
          fcnt_d  = '0;
          frame_d = 1'b1;
        end else if (early) begin
          fault = 1'b1;
        end else if (missing) begin
          // Flywheel: behave as if the marker had landed on time.
          dcnt_d = CW'(1);
          fault  = 1'b1;
        end
        if (fault) begin
          err_d  = 1'b1;
          fcnt_d = fcnt_q + FW'(1);
          if (errcnt_q != 8'hFF) errcnt_d = errcnt_q + 8'd1;
          if (fcnt_q == LOSS_N - FW'(1)) state_d = S_HUNT;
        end
      end
      default: state_d = S_HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      i320_d_q     <= 1'b0;
      mbr_d_q      <= 1'b0;
      slot_q       <= 1'b0;
      mark_q       <= 1'b0;
      state_q      <= S_HUNT;
      dcnt_q       <= '0;
      gcnt_q       <= '0;
      fcnt_q       <= '0;
      errcnt_q     <= '0;
      frame_q      <= 1'b0;
      err_q        <= 1'b0;
      slot_out_q   <= '0;
      frame_out_q  <= 1'b0;
      lock_out_q   <= 1'b0;
      err_out_q    <= 1'b0;
      errcnt_out_q <= '0;
    end else begin
      i320_d_q     <= i320;
      mbr_d_q      <= iMBR;
      slot_q       <= slot_d;
      mark_q       <= mark_d;
      state_q      <= state_d;
      dcnt_q       <= dcnt_d;
      gcnt_q       <= gcnt_d;
      fcnt_q       <= fcnt_d;
      errcnt_q     <= errcnt_d;
      frame_q      <= frame_d;
      err_q        <= err_d;
      slot_out_q   <= dcnt_q;
      frame_out_q  <= frame_q;
      lock_out_q   <= (state_q == S_LOCK);
      err_out_q    <= err_q;
      errcnt_out_q <= errcnt_q;
    end
  end

  assign oSlot   = slot_out_q;
  assign oFrame  = frame_out_q;
  assign oLock   = lock_out_q;
  assign oErr    = err_out_q;
  assign oErrCnt = errcnt_out_q;

endmodule
